// File: rtl/mem_arb_pkg.sv
// Shared types and constants for mem_port_arbiter: FSM states, requester sides,
// line geometry and default MMIO addresses.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        MMIO = 2'd2,
        RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } arb_side_e;

    localparam int LINE_W_DEF = 256;
    localparam int LINE_BYTES = LINE_W_DEF / 8;
    localparam int LINE_OFF_W = $clog2(LINE_BYTES);

    localparam logic [31:0] STDOUT_ADDR_DEF = 32'hf000_0000;
    localparam logic [31:0] EXIT_ADDR_DEF   = 32'hff00_0000;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Down-counting timeout for the arbiter's memory wait; loaded on entry to MEM,
// flags expiry once CYCLES cycles have been spent waiting.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(CYCLES - 1);
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The last waiting cycle is the one in which the count reads zero.
    assign expired_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin merge of the I-cache and D-cache miss ports onto one line-wide memory
// port, with local STDOUT/EXIT write decode. Optional memory watchdog: MEM_ARB_WATCHDOG_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                LINE_W      = LINE_W_DEF,
    parameter logic [ADDR_W-1:0] STDOUT_ADDR = ADDR_W'(STDOUT_ADDR_DEF),
    parameter logic [ADDR_W-1:0] EXIT_ADDR   = ADDR_W'(EXIT_ADDR_DEF),
    parameter int                WDOG_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imreq,
    input  logic [ADDR_W-1:0] iad,
    output logic              acki_n,
    output logic [LINE_W-1:0] idt,
    input  logic              dmreq,
    input  logic              dmwrite,
    input  logic [ADDR_W-1:0] dad,
    input  logic [LINE_W-1:0] ddt_w,
    output logic              ackd_n,
    output logic [LINE_W-1:0] ddt_r,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [LINE_W-1:0] m_rdata,
    output logic              stdout_valid,
    output logic [7:0]        stdout_byte,
    output logic              exit_o,
    output logic              wdog_err
);

    localparam int OFF_W = $clog2(LINE_W / 8);

    if (WDOG_CYCLES < 1) begin : g_wdog_range
        $error("mem_port_arbiter: WDOG_CYCLES must be at least 1");
    end

    arb_state_e        state_q, state_d;
    arb_side_e         last_grant_q, last_grant_d;
    arb_side_e         side_q, side_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              acki_n_q, acki_n_d;
    logic              ackd_n_q, ackd_n_d;
    logic [LINE_W-1:0] idt_q, idt_d;
    logic [LINE_W-1:0] ddt_r_q, ddt_r_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [LINE_W-1:0] m_wdata_q, m_wdata_d;
    logic              stdout_valid_q, stdout_valid_d;
    logic [7:0]        stdout_byte_q, stdout_byte_d;
    logic              exit_q, exit_d;

    logic grant_i, grant_d, d_mmio, wdog_expired;

    // Round-robin: on contention the side that did not win last time goes first.
    assign grant_i = imreq && (!dmreq || (last_grant_q == SIDE_D));
    assign grant_d = dmreq && !grant_i;
    assign d_mmio  = dmwrite && ((dad == STDOUT_ADDR) || (dad == EXIT_ADDR));

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        side_d         = side_q;
        addr_d         = addr_q;
        acki_n_d       = 1'b1;
        ackd_n_d       = 1'b1;
        idt_d          = idt_q;
        ddt_r_d        = ddt_r_q;
        m_req_d        = m_req_q;
        m_we_d         = m_we_q;
        m_addr_d       = m_addr_q;
        m_wdata_d      = m_wdata_q;
        stdout_valid_d = 1'b0;
        stdout_byte_d  = stdout_byte_q;
        exit_d         = exit_q;

        case (state_q)
            IDLE: begin
                if (grant_i || grant_d) begin
                    side_d       = grant_i ? SIDE_I : SIDE_D;
                    last_grant_d = side_d;
                    addr_d       = grant_i ? iad : dad;
                    if (grant_d && d_mmio) begin
                        state_d        = MMIO;
                        stdout_valid_d = (dad == STDOUT_ADDR);
                        if (dad == STDOUT_ADDR) begin
                            stdout_byte_d = ddt_w[7:0];
                        end
                    end else begin
                        state_d   = MEM;
                        m_req_d   = 1'b1;
                        m_we_d    = grant_d && dmwrite;
                        m_addr_d  = {addr_d[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        m_wdata_d = ddt_w;
                    end
                end
            end

            MEM: begin
                if (m_ack || wdog_expired) begin
                    state_d = RESP;
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    if (side_q == SIDE_I) begin
                        acki_n_d = 1'b0;
                    end else begin
                        ackd_n_d = 1'b0;
                    end
                    // A timed-out request answers with an all-zero line.
                    if (!m_ack) begin
                        if (side_q == SIDE_I) begin
                            idt_d = '0;
                        end else begin
                            ddt_r_d = '0;
                        end
                    end else if (!m_we_q) begin
                        if (side_q == SIDE_I) begin
                            idt_d = m_rdata;
                        end else begin
                            ddt_r_d = m_rdata;
                        end
                    end
                end
            end

            MMIO: begin
                if (addr_q == EXIT_ADDR) begin
                    exit_d = 1'b1;
                end
                ackd_n_d = 1'b0;
                state_d  = RESP;
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= SIDE_D;
            side_q         <= SIDE_I;
            addr_q         <= '0;
            acki_n_q       <= 1'b1;
            ackd_n_q       <= 1'b1;
            idt_q          <= '0;
            ddt_r_q        <= '0;
            m_req_q        <= 1'b0;
            m_we_q         <= 1'b0;
            m_addr_q       <= '0;
            m_wdata_q      <= '0;
            stdout_valid_q <= 1'b0;
            stdout_byte_q  <= '0;
            exit_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            side_q         <= side_d;
            addr_q         <= addr_d;
            acki_n_q       <= acki_n_d;
            ackd_n_q       <= ackd_n_d;
            idt_q          <= idt_d;
            ddt_r_q        <= ddt_r_d;
            m_req_q        <= m_req_d;
            m_we_q         <= m_we_d;
            m_addr_q       <= m_addr_d;
            m_wdata_q      <= m_wdata_d;
            stdout_valid_q <= stdout_valid_d;
            stdout_byte_q  <= stdout_byte_d;
            exit_q         <= exit_d;
        end
    end

`ifdef MEM_ARB_WATCHDOG_EN
    logic mem_enter;
    logic wdog_err_q, wdog_err_d;

    assign mem_enter = (state_q == IDLE) && (state_d == MEM);

    mem_arb_watchdog #(
        .CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .load_i    (mem_enter),
        .run_i     (state_q == MEM),
        .expired_o (wdog_expired)
    );

    always_comb begin
        wdog_err_d = wdog_err_q;
        if ((state_q == MEM) && !m_ack && wdog_expired) begin
            wdog_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_err_q <= 1'b0;
        end else begin
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    assign wdog_expired = 1'b0;
    assign wdog_err     = 1'b0;
`endif

    assign acki_n       = acki_n_q;
    assign ackd_n       = ackd_n_q;
    assign idt          = idt_q;
    assign ddt_r        = ddt_r_q;
    assign m_req        = m_req_q;
    assign m_we         = m_we_q;
    assign m_addr       = m_addr_q;
    assign m_wdata      = m_wdata_q;
    assign stdout_valid = stdout_valid_q;
    assign stdout_byte  = stdout_byte_q;
    assign exit_o       = exit_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single/contending transactions
// plus hand sequences for EXIT stickiness, reset mid-transaction and the watchdog.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk, rst;
    logic          imreq, dmreq, dmwrite, m_ack;
    logic [AW-1:0] iad, dad;
    logic [LW-1:0] ddt_w, m_rdata;
    logic          acki_n, ackd_n, m_req, m_we, stdout_valid, exit_o, wdog_err;
    logic [LW-1:0] idt, ddt_r, m_wdata;
    logic [AW-1:0] m_addr;
    logic [7:0]    stdout_byte;

    int n_applied = 0;
    int n_miscompare = 0;
    int mem_lat = 1;
    bit mem_never = 0;

    mem_port_arbiter #(
        .WDOG_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imreq        (imreq),
        .iad          (iad),
        .acki_n       (acki_n),
        .idt          (idt),
        .dmreq        (dmreq),
        .dmwrite      (dmwrite),
        .dad          (dad),
        .ddt_w        (ddt_w),
        .ackd_n       (ackd_n),
        .ddt_r        (ddt_r),
        .m_req        (m_req),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_ack        (m_ack),
        .m_rdata      (m_rdata),
        .stdout_valid (stdout_valid),
        .stdout_byte  (stdout_byte),
        .exit_o       (exit_o),
        .wdog_err     (wdog_err)
    );

    typedef struct {
        logic        ireq, dreq, dwr;
        logic [31:0] iaddr, daddr;
        logic [7:0]  wbyte;
        int          lat;
        int          i_ack, d_ack, mreq_cyc, stdout_n;
        logic [7:0]  sbyte;
        logic [31:0] i_maddr, d_maddr;
    } vec_t;

    vec_t tbl[13];

    function automatic logic [LW-1:0] mdata(input logic [31:0] a);
        logic [LW-1:0] d;
        for (int k = 0; k < 8; k++) begin
            d[k*32 +: 32] = a ^ (32'h1357_9bdf + 32'(k) * 32'h0101_0101);
        end
        return d;
    endfunction

    function automatic logic [LW-1:0] wline(input logic [7:0] b);
        return {{31{8'h5c}}, b};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miscompare++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: acks after mem_lat cycles of m_req, returns an address-derived line.
    initial begin
        int cnt;
        cnt = 0;
        m_ack = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_ack = 1'b0;
                cnt = 0;
            end else if (m_ack) begin
                m_ack = 1'b0;
                cnt = 0;
            end else if (m_req && !mem_never) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    m_ack = 1'b1;
                    m_rdata = mdata(m_addr);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int c, mreq_cyc, stdout_cnt;
        bit i_done, d_done, inflight_d;
        logic [7:0] sbyte;
        logic [31:0] exp_ma;
        i_done = !v.ireq;
        d_done = !v.dreq;
        c = 0; mreq_cyc = 0; stdout_cnt = 0; sbyte = '0;
        imreq = v.ireq; iad = v.iaddr;
        dmreq = v.dreq; dmwrite = v.dwr; dad = v.daddr; ddt_w = wline(v.wbyte);
        mem_lat = v.lat;
        while (!(i_done && d_done) && c < 200) begin
            @(negedge clk);
            c++;
            if (v.ireq && v.dreq) inflight_d = (v.i_ack < v.d_ack) ? i_done : !d_done;
            else inflight_d = v.dreq;
            if (m_req) begin
                mreq_cyc++;
                exp_ma = inflight_d ? v.d_maddr : v.i_maddr;
                chk({tag, " m_addr"}, LW'(m_addr), LW'(exp_ma));
                chk({tag, " m_we"}, LW'(m_we), LW'(inflight_d && v.dwr));
                if (inflight_d && v.dwr) chk({tag, " m_wdata"}, m_wdata, wline(v.wbyte));
            end
            if (stdout_valid) begin
                stdout_cnt++;
                sbyte = stdout_byte;
            end
            if (!acki_n) begin
                if (i_done) chk({tag, " acki spurious"}, 1, 0);
                else begin
                    chk({tag, " acki cycle"}, LW'(c), LW'(v.i_ack));
                    chk({tag, " idt"}, idt, mdata(v.i_maddr));
                    i_done = 1'b1;
                    imreq = 1'b0;
                end
            end
            if (!ackd_n) begin
                if (d_done) chk({tag, " ackd spurious"}, 1, 0);
                else begin
                    chk({tag, " ackd cycle"}, LW'(c), LW'(v.d_ack));
                    if (!v.dwr) chk({tag, " ddt_r"}, ddt_r, mdata(v.d_maddr));
                    d_done = 1'b1;
                    dmreq = 1'b0;
                end
            end
        end
        if (!(i_done && d_done)) begin
            chk({tag, " ack timeout"}, 0, 1);
            imreq = 1'b0;
            dmreq = 1'b0;
        end
        chk({tag, " m_req cycles"}, LW'(mreq_cyc), LW'(v.mreq_cyc));
        chk({tag, " stdout pulses"}, LW'(stdout_cnt), LW'(v.stdout_n));
        if (v.stdout_n > 0) chk({tag, " stdout_byte"}, LW'(sbyte), LW'(v.sbyte));
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " acki_n"}, LW'(acki_n), 1);
        chk({tag, " ackd_n"}, LW'(ackd_n), 1);
        chk({tag, " idt"}, idt, 0);
        chk({tag, " ddt_r"}, ddt_r, 0);
        chk({tag, " m_req"}, LW'(m_req), 0);
        chk({tag, " m_we"}, LW'(m_we), 0);
        chk({tag, " m_addr"}, LW'(m_addr), 0);
        chk({tag, " m_wdata"}, m_wdata, 0);
        chk({tag, " stdout_valid"}, LW'(stdout_valid), 0);
        chk({tag, " exit_o"}, LW'(exit_o), 0);
        chk({tag, " wdog_err"}, LW'(wdog_err), 0);
    endtask

    initial begin
        vec_t v;
        //         ireq dreq dwr iaddr         daddr         wbyte  lat iack dack mreq so sbyte  i_maddr       d_maddr
        tbl[0]  = '{1'b0,1'b1,1'b0,32'h0,        32'h40,       8'h00, 1, 0, 2, 1, 0, 8'h00, 32'h0,        32'h40};
        tbl[1]  = '{1'b1,1'b0,1'b0,32'h100,      32'h0,        8'h00, 3, 4, 0, 3, 0, 8'h00, 32'h100,      32'h0};
        tbl[2]  = '{1'b0,1'b1,1'b0,32'h0,        32'h2e4,      8'h00, 2, 0, 3, 2, 0, 8'h00, 32'h0,        32'h2e0};
        tbl[3]  = '{1'b1,1'b1,1'b0,32'h500,      32'h600,      8'h00, 2, 3, 7, 4, 0, 8'h00, 32'h500,      32'h600};
        tbl[4]  = '{1'b1,1'b1,1'b1,32'h520,      32'h6a0,      8'h77, 2, 3, 7, 4, 0, 8'h00, 32'h520,      32'h6a0};
        tbl[5]  = '{1'b0,1'b1,1'b1,32'h0,        32'h1234_5678,8'h99, 4, 0, 5, 4, 0, 8'h00, 32'h0,        32'h1234_5660};
        tbl[6]  = '{1'b0,1'b1,1'b1,32'h0,        32'hf000_0000,8'h41, 1, 0, 2, 0, 1, 8'h41, 32'h0,        32'h0};
        tbl[7]  = '{1'b0,1'b1,1'b0,32'h0,        32'hf000_0000,8'h00, 3, 0, 4, 3, 0, 8'h00, 32'h0,        32'hf000_0000};
        tbl[8]  = '{1'b0,1'b1,1'b1,32'h0,        32'hf000_0004,8'h42, 1, 0, 2, 1, 0, 8'h00, 32'h0,        32'hf000_0000};
        tbl[9]  = '{1'b1,1'b1,1'b1,32'hf000_0000,32'hf000_0000,8'h43, 2, 3, 6, 2, 1, 8'h43, 32'hf000_0000,32'h0};
        tbl[10] = '{1'b1,1'b0,1'b0,32'h1f,       32'h0,        8'h00, 1, 2, 0, 1, 0, 8'h00, 32'h0,        32'h0};
        tbl[11] = '{1'b1,1'b1,1'b0,32'h7c0,      32'h840,      8'h00, 1, 5, 2, 2, 0, 8'h00, 32'h7c0,      32'h840};
        tbl[12] = '{1'b1,1'b1,1'b0,32'h900,      32'ha00,      8'h00, 3, 9, 4, 6, 0, 8'h00, 32'h900,      32'ha00};

        rst = 1'b1;
        imreq = 1'b0; dmreq = 1'b0; dmwrite = 1'b0;
        iad = '0; dad = '0; ddt_w = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // EXIT is sticky across later traffic and only cleared by reset.
        v = '{1'b0,1'b1,1'b1,32'h0,32'hff00_0000,8'h00,1,0,2,0,0,8'h00,32'h0,32'h0};
        run_vec(v, "exit");
        chk("exit set", LW'(exit_o), 1);
        for (int k = 0; k < 10; k++) begin
            v = '{1'b1,1'b0,1'b0,32'h1000 + 32'(k*64),32'h0,8'h00,(k%3)+1,(k%3)+2,0,(k%3)+1,0,8'h00,
                  32'h1000 + 32'(k*64),32'h0};
            run_vec(v, $sformatf("post_exit%0d", k));
            chk($sformatf("exit sticky %0d", k), LW'(exit_o), 1);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("exit cleared by rst", LW'(exit_o), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("exit after rst release", LW'(exit_o), 0);

        // Reset in the middle of a memory wait.
        imreq = 1'b1; iad = 32'h3000; mem_lat = 20;
        repeat (3) @(negedge clk);
        chk("midmem m_req before rst", LW'(m_req), 1);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("midmem");
        imreq = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        v = '{1'b1,1'b0,1'b0,32'h80,32'h0,8'h00,2,3,0,2,0,8'h00,32'h80,32'h0};
        run_vec(v, "after_rst");

`ifdef MEM_ARB_WATCHDOG_EN
        begin
            int c, mc, ack_c;
            v = '{1'b0,1'b1,1'b0,32'h0,32'h2e0,8'h00,1,0,2,1,0,8'h00,32'h0,32'h2e0};
            run_vec(v, "pre_wdog");
            mem_never = 1'b1;
            dmreq = 1'b1; dmwrite = 1'b0; dad = 32'h440;
            c = 0; mc = 0; ack_c = 0;
            while (ack_c == 0 && c < 40) begin
                @(negedge clk);
                c++;
                if (m_req) mc++;
                if (!ackd_n) begin
                    ack_c = c;
                    chk("wdog ddt_r zero", ddt_r, 0);
                    dmreq = 1'b0;
                end
            end
            dmreq = 1'b0;
            chk("wdog ack cycle", LW'(ack_c), 9);
            chk("wdog m_req cycles", LW'(mc), 8);
            chk("wdog_err set", LW'(wdog_err), 1);
            mem_never = 1'b0;
            repeat (2) @(negedge clk);
        end
`else
        chk("wdog_err tied", LW'(wdog_err), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule
